// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for the counter sequencer
//
// Purpose: FSM state encoding, run-mode limit default and the manual/run
//          action encoding with its fixed-priority selector.
`timescale 1ns/1ps
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LIMIT = 2'd2
  } state_t;

  localparam logic [15:0] RUN_LIMIT_DEFAULT = 16'hFFFC;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2,
    LD   = 2'd3
  } action_t;

  // One winner per cycle: load edge, then up edge, then down edge, then the
  // run-mode tick. Losers are dropped, never queued.
  function automatic action_t pick_action(input logic ld_edge,
                                          input logic up_edge,
                                          input logic dw_edge,
                                          input logic run_inc);
    if (ld_edge)      return LD;
    else if (up_edge) return INC;
    else if (dw_edge) return DEC;
    else if (run_inc) return INC;
    else              return NONE;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - button synchronizer with rising-edge detect
//
// Purpose: brings one asynchronous button into the clk domain and flags its
//          rising edge for one cycle.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   din   in  raw asynchronous button
//   lvl   out synchronized level
//   rise  out one-cycle pulse when lvl goes 0 -> 1
`timescale 1ns/1ps
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // prev_q clears on reset, so a button held through reset still yields
  // exactly one rise once the synchronizer refills after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - button/run-mode sequencer for the display counter
//
// Purpose: converts up/down/load buttons and run mode into one-cycle,
//          mutually exclusive inc/dec/ld commands for the 16-bit counter.
// Ports:
//   clkin     in  system clock
//   reset     in  synchronous active-high reset
//   btn_up    in  raw increment button
//   btn_dw    in  raw decrement button
//   btn_ld    in  raw load button
//   btn_run   in  raw run button (level)
//   tick      in  run-rate strobe, one cycle wide
//   sw        in  load value
//   q         in  current counter value
//   inc       out one-cycle increment command
//   dec       out one-cycle decrement command
//   ld        out one-cycle load command
//   ld_data   out load value, captured with ld
//   running   out state is RUN
//   limit_hit out state is LIMIT
`timescale 1ns/1ps
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RUN_LIMIT   = RUN_LIMIT_DEFAULT
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_dw,
  input  logic             btn_ld,
  input  logic             btn_run,
  input  logic             tick,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH-1:0] q,
  output logic             inc,
  output logic             dec,
  output logic             ld,
  output logic [WIDTH-1:0] ld_data,
  output logic             running,
  output logic             limit_hit
);

  logic    up_rise, dw_rise, ld_rise;
  logic    up_lvl_unused, dw_lvl_unused, ld_lvl_unused, run_rise_unused;
  logic    run_s;
  logic    below_limit;
  logic    tick_inc;
  state_t  state_q, state_nxt;
  action_t action;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
    .clk(clkin), .reset(reset), .din(btn_up), .lvl(up_lvl_unused), .rise(up_rise)
  );
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dw (
    .clk(clkin), .reset(reset), .din(btn_dw), .lvl(dw_lvl_unused), .rise(dw_rise)
  );
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld (
    .clk(clkin), .reset(reset), .din(btn_ld), .lvl(ld_lvl_unused), .rise(ld_rise)
  );
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
    .clk(clkin), .reset(reset), .din(btn_run), .lvl(run_s), .rise(run_rise_unused)
  );

  assign below_limit = (q < RUN_LIMIT);

  always_comb begin
    state_nxt = state_q;
    tick_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_s) state_nxt = below_limit ? RUN : LIMIT;
      end
      RUN: begin
        // Releasing run wins over a tick arriving in the same cycle.
        if (!run_s) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (below_limit) tick_inc  = 1'b1;
          else             state_nxt = LIMIT;
        end
      end
      LIMIT: begin
        if (!run_s)          state_nxt = IDLE;
        else if (below_limit) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    // A manual edge in the same cycle outranks the tick, so that tick's
    // increment is simply lost.
    action = pick_action(ld_rise, up_rise, dw_rise, tick_inc);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q   <= IDLE;
      inc       <= 1'b0;
      dec       <= 1'b0;
      ld        <= 1'b0;
      ld_data   <= '0;
      running   <= 1'b0;
      limit_hit <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      inc       <= (action == INC);
      dec       <= (action == DEC);
      ld        <= (action == LD);
      if (action == LD) ld_data <= sw;
      running   <= (state_nxt == RUN);
      limit_hit <= (state_nxt == LIMIT);
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed self-checking bench for counter_ctrl
`timescale 1ns/1ps
module tb_counter_ctrl;

  logic        clkin = 1'b0;
  logic        reset;
  logic        btn_up, btn_dw, btn_ld, btn_run, tick;
  logic [15:0] sw, q;
  logic        inc, dec, ld, running, limit_hit;
  logic [15:0] ld_data;

  int n_vec = 0;
  int n_bad = 0;
  int n_inc, n_dec, n_ld, n_multi;

  always #5 clkin = ~clkin;

  counter_ctrl dut (
    .clkin(clkin), .reset(reset),
    .btn_up(btn_up), .btn_dw(btn_dw), .btn_ld(btn_ld), .btn_run(btn_run),
    .tick(tick), .sw(sw), .q(q),
    .inc(inc), .dec(dec), .ld(ld), .ld_data(ld_data),
    .running(running), .limit_hit(limit_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: the counter model applies whatever command was visible
  // before the edge, then the new outputs are tallied 1ns after it.
  task automatic step(input int n = 1);
    logic        c_inc, c_dec, c_ld;
    logic [15:0] c_data;
    for (int i = 0; i < n; i++) begin
      c_inc = inc; c_dec = dec; c_ld = ld; c_data = ld_data;
      @(posedge clkin);
      #1;
      if (c_ld)       q = c_data;
      else if (c_inc) q = q + 16'd1;
      else if (c_dec) q = q - 16'd1;
      if (inc) n_inc++;
      if (dec) n_dec++;
      if (ld)  n_ld++;
      if ((int'(inc) + int'(dec) + int'(ld)) > 1) n_multi++;
    end
  endtask

  task automatic clr();
    n_inc = 0; n_dec = 0; n_ld = 0;
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b1; btn_dw = 1'b0; btn_ld = 1'b0; btn_run = 1'b0;
    tick = 1'b0; sw = 16'h0000; q = 16'h0000; n_multi = 0;
    clr();

    // Reset, with btn_up held throughout
    step(3);
    chk("rst_ctrl", 32'({inc, dec, ld, running, limit_hit}), 32'h0);
    chk("rst_ld_data", 32'(ld_data), 32'h0);
    reset = 1'b0;
    clr();
    step(6);
    chk("held_thru_rst_inc", 32'(n_inc), 32'd1);
    chk("held_thru_rst_q", 32'(q), 32'h0001);
    btn_up = 1'b0;
    step(3);

    // Load: one ld at k+2 for a 50-cycle press
    sw = 16'h9034; clr();
    btn_ld = 1'b1;
    step(2);
    chk("ld_early", 32'(ld), 32'd0);
    step(1);
    chk("ld_at_k2", 32'(ld), 32'd1);
    chk("ld_data", 32'(ld_data), 32'h9034);
    step(47);
    chk("ld_count", 32'(n_ld), 32'd1);
    chk("ld_no_incdec", 32'(n_inc + n_dec), 32'd0);
    btn_ld = 1'b0; sw = 16'h1111;
    step(4);
    chk("ld_data_hold", 32'(ld_data), 32'h9034);
    chk("ld_q", 32'(q), 32'h9034);

    // Priority: ld > up > dw
    clr();
    btn_ld = 1'b1; btn_up = 1'b1; btn_dw = 1'b1;
    step(6);
    chk("prio3_ld", 32'(n_ld), 32'd1);
    chk("prio3_incdec", 32'(n_inc + n_dec), 32'd0);
    btn_ld = 1'b0; btn_up = 1'b0; btn_dw = 1'b0;
    step(4);
    clr();
    btn_up = 1'b1; btn_dw = 1'b1;
    step(6);
    chk("prio2_inc", 32'(n_inc), 32'd1);
    chk("prio2_dec", 32'(n_dec + n_ld), 32'd0);
    btn_up = 1'b0; btn_dw = 1'b0;
    step(4);
    chk("prio_q", 32'(q), 32'h1112);

    // Run to limit from FFF0
    q = 16'hFFF0; clr();
    btn_run = 1'b1;
    for (int i = 0; i < 250; i++) begin
      tick = ((i % 10) == 9);
      step(1);
      if (i == 50) chk("run_running", 32'(running), 32'd1);
    end
    tick = 1'b0;
    chk("run_inc_count", 32'(n_inc), 32'd12);
    chk("run_q_stop", 32'(q), 32'hFFFC);
    chk("run_limit_hit", 32'({running, limit_hit}), 32'b01);
    btn_run = 1'b0;
    step(2);
    chk("rel_still_limit", 32'(limit_hit), 32'd1);
    step(1);
    chk("rel_idle", 32'({running, limit_hit}), 32'b00);

    // Tick colliding with a down edge in RUN
    q = 16'h0100; clr();
    btn_run = 1'b1;
    step(5);
    chk("coll_running", 32'(running), 32'd1);
    btn_dw = 1'b1;
    step(2);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("coll_dec_only", 32'({inc, dec}), 32'b01);
    btn_dw = 1'b0;
    step(3);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("coll_next_tick_inc", 32'(inc), 32'd1);
    step(2);
    chk("coll_q", 32'(q), 32'h0100);
    btn_run = 1'b0;
    step(4);
    chk("coll_idle", 32'(running), 32'd0);

    // Manual wrap, then load out of LIMIT back into RUN
    q = 16'hFFFF;
    btn_up = 1'b1;
    step(3);
    chk("wrap_inc", 32'(inc), 32'd1);
    btn_up = 1'b0;
    step(2);
    chk("wrap_q", 32'(q), 32'h0000);
    q = 16'hFFFD;
    btn_run = 1'b1;
    step(4);
    chk("lim_enter", 32'({running, limit_hit}), 32'b01);
    sw = 16'h0010;
    btn_ld = 1'b1;
    step(3);
    chk("lim_ld", 32'({ld, ld_data}), {15'd0, 1'b1, 16'h0010});
    btn_ld = 1'b0;
    step(2);
    chk("lim_back_to_run", 32'({running, limit_hit}), 32'b10);

    // Reset mid-run with a tick pending
    tick = 1'b1; reset = 1'b1;
    step(1);
    tick = 1'b0;
    chk("midrst_outs", 32'({inc, dec, ld, running, limit_hit}), 32'h0);
    chk("midrst_ld_data", 32'(ld_data), 32'h0);
    reset = 1'b0;
    step(2);
    chk("midrst_not_yet", 32'(running), 32'd0);
    step(1);
    chk("midrst_rerun", 32'(running), 32'd1);
    btn_run = 1'b0;
    step(4);

    chk("one_hot_cmds", 32'(n_multi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
